seg_subtractor: RTL and testbench

SEG_SUBTRACTOR -- requirements
Module: seg_subtractor

---
 rtl/alu_pkg.sv | 19 +
 rtl/seg_sub.sv | 27 ++
 rtl/seg_subtractor.sv | 154 +++++++++++++++
 tb/tb_seg_subtractor.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and sizing helpers for the segmented subtractor.
// Holds the FSM state enum and the NSEG / index-width derivation.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nseg_f(input int w, input int s);
    return (s > 0) ? (w / s) : 1;
  endfunction

  function automatic int idx_w_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_sub.sv
// SEG-bit ripple full-subtractor chain.
// Ports: x_i, y_i slice operands; b_i borrow-in; d_o difference; b_o borrow-out.
module seg_sub #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] x_i,
  input  logic [SEG-1:0] y_i,
  input  logic           b_i,
  output logic [SEG-1:0] d_o,
  output logic           b_o
);

  logic c;

  always_comb begin
    c   = b_i;
    d_o = '0;
    for (int i = 0; i < SEG; i++) begin
      d_o[i] = x_i[i] ^ y_i[i] ^ c;
      c = (~x_i[i] & y_i[i]) |
          (~x_i[i] & c) |
          (y_i[i] & c);
    end
    b_o = c;
  end

endmodule

// File: rtl/seg_subtractor.sv
// Multi-cycle subtractor: z = x - y - b, SEG bits per clock, LSB slice first.
// Ports: clk, rst (sync, active-high); in_valid/in_ready operand handshake;
// x, y, b operands; out_valid/out_ready result handshake; z, b_next result.
// Optional SEG_SUBTRACTOR_FLAGS_EN adds registered zero and ovf outputs.
module seg_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             b_next
`ifdef SEG_SUBTRACTOR_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int NSEG = nseg_f(WIDTH, SEG);
  localparam int IW   = idx_w_f(NSEG);
  localparam logic [IW-1:0] LAST = IW'(NSEG - 1);

  generate
    if (SEG < 1 || WIDTH < 1 || (WIDTH % SEG) != 0) begin : g_bad_cfg
      $error("seg_subtractor: WIDTH must be a positive multiple of SEG");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             bn_q, bn_d;

`ifdef SEG_SUBTRACTOR_FLAGS_EN
  logic zero_q, zero_d;
  logic ovf_q, ovf_d;
`endif

  logic [SEG-1:0] xs, ys, ds;
  logic           bo;

  assign xs = x_q[int'(idx_q)*SEG +: SEG];
  assign ys = y_q[int'(idx_q)*SEG +: SEG];

  seg_sub #(
    .SEG(SEG)
  ) u_sub (
    .x_i(xs),
    .y_i(ys),
    .b_i(brw_q),
    .d_o(ds),
    .b_o(bo)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    brw_d     = brw_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    bn_d      = bn_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef SEG_SUBTRACTOR_FLAGS_EN
    zero_d = zero_q;
    ovf_d  = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = x;
          y_d     = y;
          brw_d   = b;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        z_d[int'(idx_q)*SEG +: SEG] = ds;
        brw_d = bo;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          bn_d    = bo;
          state_d = DONE;
`ifdef SEG_SUBTRACTOR_FLAGS_EN
          zero_d = (z_d == '0);
          // top slice MSB is the result sign bit
          ovf_d  = (x_q[WIDTH-1] != y_q[WIDTH-1]) &&
                   (ds[SEG-1] != x_q[WIDTH-1]);
`endif
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      brw_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      bn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      brw_q   <= brw_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      bn_q    <= bn_d;
    end
  end

`ifdef SEG_SUBTRACTOR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign zero = zero_q;
  assign ovf  = ovf_q;
`endif

  assign z      = z_q;
  assign b_next = bn_q;

endmodule

// File: tb/tb_seg_subtractor.sv
// Testbench for seg_subtractor (WIDTH=16, SEG=4).
// Scoreboard of expected results; per-scenario tasks compare inline.
module tb_seg_subtractor;

  localparam int W = 16;
  localparam int S = 4;
  localparam int N = W / S;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;
  logic         b_next;
`ifdef SEG_SUBTRACTOR_FLAGS_EN
  logic         zero;
  logic         ovf;
`endif

  seg_subtractor #(
    .WIDTH(W),
    .SEG(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .x(x),
    .y(y),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .z(z),
    .b_next(b_next)
`ifdef SEG_SUBTRACTOR_FLAGS_EN
    ,
    .zero(zero),
    .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] z;
    logic         bn;
    logic         zf;
    logic         of;
  } exp_t;

  exp_t sb[$];
  int   cmp = 0;
  int   bad = 0;

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] c,
                                 input logic bi);
    logic [W:0] r;
    exp_t e;
    r    = {1'b0, a} - {1'b0, c} - (W+1)'(bi);
    e.z  = r[W-1:0];
    e.bn = r[W];
    e.zf = (r[W-1:0] == '0);
    e.of = (a[W-1] != c[W-1]) && (r[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted; scramble inputs afterwards.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] c,
                        input logic bi, output bit ok);
    x = a; y = c; b = bi; in_valid = 1'b1; ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) begin
        sb.push_back(model(a, c, bi));
        ok = 1;
      end
      step();
    end
    in_valid = 1'b0;
    x = ~a; y = ~c; b = ~bi;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; x = 16'h0F0F; y = 16'h0101; b = 1'b1;
    step();
    step();
    cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    cmp++;
    if (z !== '0 || b_next !== 1'b0) begin
      bad++;
      $display("FAIL reset_val: z=%h b_next=%b want 0000/0", z, b_next);
    end
`ifdef SEG_SUBTRACTOR_FLAGS_EN
    cmp++;
    if (zero !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: zero=%b ovf=%b want 0/0", zero, ovf);
    end
`endif
    rst = 1'b0; in_valid = 1'b0;
    step();
    cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] va[13];
    logic [W-1:0] vb[13];
    logic         vc[13];
    bit ok;
    int lat;
    exp_t e;
    va[0] = 16'h0005; vb[0] = 16'h0003; vc[0] = 1'b0;
    va[1] = 16'h0000; vb[1] = 16'h0001; vc[1] = 1'b0;
    va[2] = 16'h8000; vb[2] = 16'h0001; vc[2] = 1'b0;
    va[3] = 16'h1234; vb[3] = 16'h1234; vc[3] = 1'b0;
    va[4] = 16'hFFFF; vb[4] = 16'hFFFF; vc[4] = 1'b1;
    va[5] = 16'h0000; vb[5] = 16'h0000; vc[5] = 1'b1;
    va[6] = 16'hABCD; vb[6] = 16'h1234; vc[6] = 1'b1;
    for (int i = 7; i < 13; i++) begin
      va[i] = W'($urandom); vb[i] = W'($urandom); vc[i] = 1'($urandom);
    end
    for (int i = 0; i < 13; i++) begin
      accept(va[i], vb[i], vc[i], ok);
      cmp++;
      if (!ok) begin
        bad++;
        $display("FAIL accept_%0d: in_ready never seen, want accept", i);
        continue;
      end
      wait_out(lat);
      cmp++;
      if (lat != N) begin
        bad++;
        $display("FAIL latency_%0d: %0d edges want %0d", i, lat, N);
      end
      if (!out_valid) begin
        void'(sb.pop_front());
        continue;
      end
      e = sb.pop_front();
      cmp++;
      if (z !== e.z || b_next !== e.bn) begin
        bad++;
        $display("FAIL result_%0d: z=%h b_next=%b want %h/%b", i, z, b_next, e.z, e.bn);
      end
`ifdef SEG_SUBTRACTOR_FLAGS_EN
      cmp++;
      if (zero !== e.zf || ovf !== e.of) begin
        bad++;
        $display("FAIL flags_%0d: zero=%b ovf=%b want %b/%b", i, zero, ovf, e.zf, e.of);
      end
`endif
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL release_%0d: out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int lat;
    exp_t e;
    accept(16'h0ABC, 16'h0123, 1'b0, ok);
    wait_out(lat);
    cmp++;
    if (!ok || !out_valid) begin
      bad++;
      $display("FAIL stall_start: out_valid=%b want 1", out_valid);
      sb.delete();
      return;
    end
    e = sb[0];
    for (int i = 0; i < 10; i++) begin
      cmp++;
      if (out_valid !== 1'b1 || z !== e.z || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_%0d: out_valid=%b z=%h in_ready=%b want 1/%h/0",
                 i, out_valid, z, in_ready, e.z);
      end
      step();
    end
    e = sb.pop_front();
    cmp++;
    if (z !== e.z || b_next !== e.bn) begin
      bad++;
      $display("FAIL stall_result: z=%h b_next=%b want %h/%b", z, b_next, e.z, e.bn);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    bit ok;
    int lat;
    bit seen;
    exp_t e;
    accept(16'h5555, 16'h1111, 1'b0, ok);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || z !== '0 || b_next !== 1'b0) begin
      bad++;
      $display("FAIL midrun_rst: in_ready=%b out_valid=%b z=%h b_next=%b want 1/0/0000/0",
               in_ready, out_valid, z, b_next);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1;
      step();
    end
    cmp++;
    if (seen) begin
      bad++;
      $display("FAIL stale_out: out_valid seen=1 want 0");
    end
    accept(16'h1234, 16'h1234, 1'b1, ok);
    wait_out(lat);
    cmp++;
    if (!ok || !out_valid) begin
      bad++;
      $display("FAIL post_rst_txn: out_valid=%b want 1", out_valid);
      sb.delete();
      return;
    end
    e = sb.pop_front();
    cmp++;
    if (z !== 16'hFFFF || b_next !== 1'b1 || z !== e.z) begin
      bad++;
      $display("FAIL post_rst_result: z=%h b_next=%b want ffff/1", z, b_next);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int last;
    int cyc;
    int acc;
    exp_t e;
    last = -1; cyc = 0; acc = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    while (acc < 8 && cyc < 200) begin
      x = W'($urandom); y = W'($urandom); b = 1'($urandom);
      if (in_ready) begin
        sb.push_back(model(x, y, b));
        if (last >= 0) begin
          cmp++;
          if (cyc - last != N + 2) begin
            bad++;
            $display("FAIL b2b_period: %0d cycles want %0d", cyc - last, N + 2);
          end
        end
        last = cyc;
        acc++;
      end
      if (out_valid) begin
        e = sb.pop_front();
        cmp++;
        if (z !== e.z || b_next !== e.bn) begin
          bad++;
          $display("FAIL b2b_result: z=%h b_next=%b want %h/%b", z, b_next, e.z, e.bn);
        end
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 50 && sb.size() > 0; i++) begin
      if (out_valid) begin
        e = sb.pop_front();
        cmp++;
        if (z !== e.z || b_next !== e.bn) begin
          bad++;
          $display("FAIL b2b_drain: z=%h b_next=%b want %h/%b", z, b_next, e.z, e.bn);
        end
      end
      step();
    end
    cmp++;
    if (sb.size() != 0 || acc != 8) begin
      bad++;
      $display("FAIL b2b_count: pending=%0d accepted=%0d want 0/8", sb.size(), acc);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; b = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_reset_midrun();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
